// File: rtl/fft_out_streamer.sv
// fft_out_streamer: double-buffered capture of parallel FFT frames, replayed
// as a LANES-wide valid/ready beat stream in capture order.
module fft_out_streamer #(
  parameter int unsigned N_BINS = 512,
  parameter int unsigned LANES  = 16,
  parameter int unsigned DW     = 13
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           fft_en,
  input  logic [N_BINS-1:0][DW-1:0]      fft_re,
  input  logic [N_BINS-1:0][DW-1:0]      fft_im,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES-1:0][DW-1:0]       out_re,
  output logic [LANES-1:0][DW-1:0]       out_im,
  output logic [4:0]                     out_beat,
  output logic                           out_last,
  input  logic                           ovf_clr,
  output logic                           overflow,
  output logic [7:0]                     drop_cnt
);

  localparam int unsigned BEATS = N_BINS / LANES;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state;

  // Banks are stored beat-major so a beat is a single slice; the bit layout
  // is identical to the natural-order input vector.
  logic [BEATS-1:0][LANES-1:0][DW-1:0] re_mem [2];
  logic [BEATS-1:0][LANES-1:0][DW-1:0] im_mem [2];

  logic [1:0] full;
  logic       wr_sel;
  logic       rd_sel;
  logic       xfer;
  logic       last_beat;
  logic       release_bank;
  logic       accept;
  logic       drop;
  logic [1:0] cap_into;

  assign out_valid    = (state == STREAM);
  assign xfer         = out_valid & out_ready;
  assign last_beat    = (out_beat == 5'(BEATS - 1));
  assign release_bank = xfer & last_beat;
  // A bank freed by this edge's final transfer can take the incoming frame.
  assign accept       = fft_en & (~full[wr_sel] | (release_bank & (rd_sel == wr_sel)));
  assign drop         = fft_en & ~accept;
  assign cap_into[0]  = accept & ~wr_sel;
  assign cap_into[1]  = accept & wr_sel;
  assign out_last     = out_valid & last_beat;

  // Frame storage: latch the whole frame into the selected bank.
  always_ff @(posedge clk) begin
    if (accept) begin
      re_mem[wr_sel] <= fft_re;
      im_mem[wr_sel] <= fft_im;
    end
  end

  // Bank occupancy, write pointer and drop accounting.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      full     <= '0;
      wr_sel   <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      for (int unsigned b = 0; b < 2; b++) begin
        if (cap_into[b])
          full[b] <= 1'b1;
        else if (release_bank && (rd_sel == 1'(b)))
          full[b] <= 1'b0;
      end
      if (accept)
        wr_sel <= ~wr_sel;
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Read FSM: stream beats of bank[rd_sel], chaining into the other bank
  // without a bubble when it is already (or just becoming) full.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state    <= IDLE;
      rd_sel   <= 1'b0;
      out_beat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (full[rd_sel] || cap_into[rd_sel])
            state <= STREAM;
        end
        STREAM: begin
          if (xfer) begin
            if (last_beat) begin
              out_beat <= '0;
              rd_sel   <= ~rd_sel;
              if (!(full[~rd_sel] || cap_into[~rd_sel]))
                state <= IDLE;
            end else begin
              out_beat <= out_beat + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat data straight from the stable bank; zero while no beat is offered.
  always_comb begin
    out_re = '0;
    out_im = '0;
    if (out_valid) begin
      out_re = re_mem[rd_sel][out_beat];
      out_im = im_mem[rd_sel][out_beat];
    end
  end

endmodule

// File: tb/tb_fft_out_streamer.sv
// Directed self-checking bench for fft_out_streamer.
module tb_fft_out_streamer;

  localparam int N_BINS = 512;
  localparam int LANES  = 16;
  localparam int DW     = 13;

  logic                        clk;
  logic                        rstn;
  logic                        fft_en;
  logic [N_BINS-1:0][DW-1:0]   fft_re;
  logic [N_BINS-1:0][DW-1:0]   fft_im;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES-1:0][DW-1:0]    out_re;
  logic [LANES-1:0][DW-1:0]    out_im;
  logic [4:0]                  out_beat;
  logic                        out_last;
  logic                        ovf_clr;
  logic                        overflow;
  logic [7:0]                  drop_cnt;

  int n_pass  = 0;
  int n_total = 0;

  fft_out_streamer #(.N_BINS(N_BINS), .LANES(LANES), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .fft_en(fft_en), .fft_re(fft_re), .fft_im(fft_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_beat(out_beat), .out_last(out_last), .ovf_clr(ovf_clr),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base);
    for (int i = 0; i < N_BINS; i++) begin
      fft_re[i] = 13'(base + i);
      fft_im[i] = 13'(-(base + i));
    end
  endtask

  function automatic logic [LANES*DW-1:0] exp_vec(input int base, input int k, input bit neg);
    logic [LANES*DW-1:0] r;
    int v;
    r = '0;
    for (int j = 0; j < LANES; j++) begin
      v = base + LANES * k + j;
      if (neg) v = -v;
      r[j*DW +: DW] = 13'(v);
    end
    return r;
  endfunction

  // Check a full offered beat: handshake, index, last flag, both lane sets.
  task automatic chk_beat(input string tag, input int base, input int k);
    chk({tag, ".valid"}, 256'(out_valid), 256'(1));
    chk({tag, ".beat"},  256'(out_beat),  256'(k));
    chk({tag, ".last"},  256'(out_last),  256'(k == 31));
    chk({tag, ".re"},    256'(out_re),    256'(exp_vec(base, k, 1'b0)));
    chk({tag, ".im"},    256'(out_im),    256'(exp_vec(base, k, 1'b1)));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 256'(out_valid), 256'(0));
    chk({tag, ".last"},  256'(out_last),  256'(0));
    chk({tag, ".re"},    256'(out_re),    256'(0));
    chk({tag, ".im"},    256'(out_im),    256'(0));
  endtask

  initial begin
    int c;
    int k;
    rstn = 1'b1; fft_en = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    fft_re = '0; fft_im = '0;
    tick(); tick();

    // Reset state
    chk_idle("rst");
    chk("rst.beat", 256'(out_beat), 256'(0));
    chk("rst.ovf",  256'(overflow), 256'(0));
    chk("rst.drop", 256'(drop_cnt), 256'(0));
    rstn = 1'b0;
    tick();

    // 1: single frame, ready always high, 1-cycle latency
    load(0); fft_en = 1'b1; out_ready = 1'b1;
    tick();
    fft_en = 1'b0;
    for (int g = 0; g < 32; g++) begin
      chk_beat("t1", 0, g);
      tick();
    end
    chk_idle("t1.end");

    // 2: ready toggling 1,0,1,0 -> 32 transfers over 63 cycles with hold
    load(0); fft_en = 1'b1; out_ready = 1'b0;
    tick();
    fft_en = 1'b0;
    c = 0; k = 0;
    while (k < 32 && c < 100) begin
      out_ready = (c % 2 == 0);
      chk_beat("t2", 0, k);
      tick();
      if (out_ready) k++;
      c++;
    end
    chk("t2.cycles", 256'(c), 256'(63));
    chk_idle("t2.end");

    // 3: two frames two cycles apart, back-to-back 64 beats
    load(0); fft_en = 1'b1; out_ready = 1'b1;
    tick();
    for (int g = 0; g < 64; g++) begin
      chk_beat("t3", (g < 32) ? 0 : 1000, g % 32);
      fft_en = 1'b0;
      if (g == 1) begin
        load(1000); fft_en = 1'b1;
      end
      tick();
    end
    fft_en = 1'b0;
    chk_idle("t3.end");

    // 4: three frames with no ready -> third dropped
    out_ready = 1'b0;
    load(0);    fft_en = 1'b1; tick();
    load(1000); tick();
    load(2000); tick();
    fft_en = 1'b0;
    chk("t4.ovf",  256'(overflow), 256'(1));
    chk("t4.drop", 256'(drop_cnt), 256'(1));
    out_ready = 1'b1;
    for (int g = 0; g < 64; g++) begin
      chk_beat("t4", (g < 32) ? 0 : 1000, g % 32);
      tick();
    end
    chk_idle("t4.end");
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("t4.clr.ovf",  256'(overflow), 256'(0));
    chk("t4.clr.drop", 256'(drop_cnt), 256'(1));

    // 5: drop coinciding with ovf_clr keeps the flag; then capture into a
    //    bank released on the same edge
    out_ready = 1'b0;
    load(0);    fft_en = 1'b1; tick();
    load(1000); tick();
    load(3000); ovf_clr = 1'b1; tick();
    fft_en = 1'b0;
    chk("t5.dropclr.ovf",  256'(overflow), 256'(1));
    chk("t5.dropclr.drop", 256'(drop_cnt), 256'(2));
    tick();
    ovf_clr = 1'b0;
    chk("t5.clr.ovf", 256'(overflow), 256'(0));
    out_ready = 1'b1;
    for (int g = 0; g < 96; g++) begin
      chk_beat("t5", (g < 32) ? 0 : ((g < 64) ? 1000 : 2000), g % 32);
      fft_en = 1'b0;
      if (g == 31) begin
        load(2000); fft_en = 1'b1;
      end
      tick();
      if (g == 31) begin
        chk("t5.acc.ovf",  256'(overflow), 256'(0));
        chk("t5.acc.drop", 256'(drop_cnt), 256'(2));
      end
    end
    fft_en = 1'b0;
    chk_idle("t5.end");

    // 6: asynchronous reset mid-frame, then a fresh frame from beat 0
    load(0); fft_en = 1'b1;
    tick();
    fft_en = 1'b0;
    for (int g = 0; g < 10; g++) tick();
    chk("t6.pre.beat", 256'(out_beat), 256'(10));
    rstn = 1'b1;
    #1;
    chk_idle("t6.rst");
    chk("t6.rst.beat", 256'(out_beat), 256'(0));
    chk("t6.rst.drop", 256'(drop_cnt), 256'(0));
    tick();
    rstn = 1'b0;
    tick();
    load(500); fft_en = 1'b1;
    tick();
    fft_en = 1'b0;
    for (int g = 0; g < 32; g++) begin
      chk_beat("t6", 500, g);
      tick();
    end
    chk_idle("t6.end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
